// File: rtl/burst_pkg.sv
// Shared types for the burst write splitter: FSM state encoding and command length type.
package burst_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAddr = 2'd1,
        StData = 2'd2
    } state_t;

    // Command length as carried on s_total (total beats minus one).
    typedef logic [15:0] total_len_t;

endpackage

// File: rtl/burst_write_splitter.sv
// Splits a long write command into bursts of at most MAX_BURST_LENGTH beats.
// Define BURST_WRITE_SPLITTER_ALIGN_EN to keep bursts inside MAX_BURST_LENGTH-aligned windows.
import burst_pkg::*;

module burst_write_splitter #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned ADDR_WIDTH       = 32,
    parameter int unsigned MAX_BURST_LENGTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] s_addr,
    input  logic [15:0]           s_total,
    input  logic                  s_cmd_valid,
    output logic                  s_cmd_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_data_valid,
    output logic                  s_data_ready,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [7:0]            m_length,
    output logic                  m_addr_valid,
    input  logic                  m_addr_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_data_valid,
    input  logic                  m_data_ready,
    output logic                  busy
);

`ifdef BURST_WRITE_SPLITTER_ALIGN_EN
    localparam bit AlignEn = 1'b1;
`else
    localparam bit AlignEn = 1'b0;
`endif

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cur_addr;
    logic [16:0]           r_remaining;
    logic [8:0]            r_beat_cnt;
    logic [ADDR_WIDTH-1:0] r_m_addr;
    logic [7:0]            r_m_length;
    logic                  r_m_addr_valid;
    logic                  r_cmd_ready;
    logic                  r_busy;

    logic [16:0]           w_cmd_rem;
    logic [8:0]            w_cmd_beats;
    logic [8:0]            w_burst_beats;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic [16:0]           w_next_rem;
    logic [8:0]            w_next_beats;
    logic                  w_in_data;
    logic                  w_data_hs;

    // Beats for the next burst; with alignment the cap shrinks to the distance to the window edge.
    function automatic logic [8:0] calc_beats(input logic [ADDR_WIDTH-1:0] addr,
                                              input logic [16:0]           rem);
        logic [ADDR_WIDTH-1:0] off;
        logic [16:0]           cap;
        off = addr & ADDR_WIDTH'(MAX_BURST_LENGTH - 1);
        cap = 17'(MAX_BURST_LENGTH) - (AlignEn ? 17'(off) : 17'd0);
        return (rem < cap) ? rem[8:0] : cap[8:0];
    endfunction

    always_comb begin
        w_cmd_rem     = {1'b0, s_total} + 17'd1;
        w_cmd_beats   = calc_beats(s_addr, w_cmd_rem);
        w_burst_beats = {1'b0, r_m_length} + 9'd1;
        w_next_addr   = r_cur_addr + ADDR_WIDTH'(w_burst_beats);
        w_next_rem    = r_remaining - 17'd1;
        w_next_beats  = calc_beats(w_next_addr, w_next_rem);
        w_in_data     = (r_state == StData);
        w_data_hs     = w_in_data && s_data_valid && m_data_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= StIdle;
            r_cur_addr     <= '0;
            r_remaining    <= '0;
            r_beat_cnt     <= '0;
            r_m_addr       <= '0;
            r_m_length     <= '0;
            r_m_addr_valid <= 1'b0;
            r_cmd_ready    <= 1'b1;
            r_busy         <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (s_cmd_valid && r_cmd_ready) begin
                        r_cur_addr     <= s_addr;
                        r_remaining    <= w_cmd_rem;
                        r_m_addr       <= s_addr;
                        r_m_length     <= 8'(w_cmd_beats - 9'd1);
                        r_m_addr_valid <= 1'b1;
                        r_cmd_ready    <= 1'b0;
                        r_busy         <= 1'b1;
                        r_state        <= StAddr;
                    end
                end
                StAddr: begin
                    if (m_addr_ready) begin
                        r_beat_cnt     <= w_burst_beats;
                        r_m_addr_valid <= 1'b0;
                        r_state        <= StData;
                    end
                end
                StData: begin
                    if (w_data_hs) begin
                        r_beat_cnt  <= r_beat_cnt - 9'd1;
                        r_remaining <= w_next_rem;
                        if (r_beat_cnt == 9'd1) begin
                            r_cur_addr <= w_next_addr;
                            if (w_next_rem != 17'd0) begin
                                r_m_addr       <= w_next_addr;
                                r_m_length     <= 8'(w_next_beats - 9'd1);
                                r_m_addr_valid <= 1'b1;
                                r_state        <= StAddr;
                            end else begin
                                r_cmd_ready <= 1'b1;
                                r_busy      <= 1'b0;
                                r_state     <= StIdle;
                            end
                        end
                    end
                end
                default: begin
                    r_state        <= StIdle;
                    r_m_addr_valid <= 1'b0;
                    r_cmd_ready    <= 1'b1;
                    r_busy         <= 1'b0;
                end
            endcase
        end
    end

    // Data path is a straight pass-through while in DATA, so no bubbles and no added latency.
    assign s_data_ready = w_in_data && m_data_ready;
    assign m_data_valid = w_in_data && s_data_valid;
    assign m_data       = s_data;

    assign s_cmd_ready  = r_cmd_ready;
    assign m_addr       = r_m_addr;
    assign m_length     = r_m_length;
    assign m_addr_valid = r_m_addr_valid;
    assign busy         = r_busy;

endmodule

// File: tb/tb_burst_write_splitter.sv
// Directed bench for burst_write_splitter (MAX_BURST_LENGTH=4); honours BURST_WRITE_SPLITTER_ALIGN_EN.
module tb_burst_write_splitter;

    logic        clk;
    logic        rst_n;
    logic [31:0] s_addr;
    logic [15:0] s_total;
    logic        s_cmd_valid;
    logic        s_cmd_ready;
    logic [31:0] s_data;
    logic        s_data_valid;
    logic        s_data_ready;
    logic [31:0] m_addr;
    logic [7:0]  m_length;
    logic        m_addr_valid;
    logic        m_addr_ready;
    logic [31:0] m_data;
    logic        m_data_valid;
    logic        m_data_ready;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] bq_addr[$];
    logic [7:0]  bq_len[$];
    logic [31:0] dq[$];

    burst_write_splitter #(
        .DATA_WIDTH      (32),
        .ADDR_WIDTH      (32),
        .MAX_BURST_LENGTH(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_addr       (s_addr),
        .s_total      (s_total),
        .s_cmd_valid  (s_cmd_valid),
        .s_cmd_ready  (s_cmd_ready),
        .s_data       (s_data),
        .s_data_valid (s_data_valid),
        .s_data_ready (s_data_ready),
        .m_addr       (m_addr),
        .m_length     (m_length),
        .m_addr_valid (m_addr_valid),
        .m_addr_ready (m_addr_ready),
        .m_data       (m_data),
        .m_data_valid (m_data_valid),
        .m_data_ready (m_data_ready),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change at posedge+1, so negedge sees exactly what the next posedge will accept.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_addr_valid && m_addr_ready) begin
                bq_addr.push_back(m_addr);
                bq_len.push_back(m_length);
            end
            if (m_data_valid && m_data_ready) dq.push_back(m_data);
        end
    end

    task automatic clear_logs();
        bq_addr.delete();
        bq_len.delete();
        dq.delete();
    endtask

    task automatic send_cmd(input logic [31:0] a, input logic [15:0] t);
        bit seen;
        seen = 1'b0;
        @(posedge clk); #1;
        s_addr      = a;
        s_total     = t;
        s_cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (s_cmd_ready) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL cmd_timeout got s_cmd_ready=0 exp=1");
        end
        @(posedge clk); #1;
        s_cmd_valid = 1'b0;
    endtask

    // Feeds n beats (base+i); returns at posedge+1 just after the final beat was taken.
    task automatic feed(input int n, input logic [31:0] base, input bit stall);
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 3000) begin
            s_data       = base + idx;
            s_data_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            m_data_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            m_addr_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (s_data_valid && s_data_ready) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        s_data_valid = 1'b0;
        m_data_ready = 1'b1;
        m_addr_ready = 1'b1;
        total++;
        if (idx != n) begin
            bad++;
            $display("FAIL feed_timeout got beats=%0d exp=%0d", idx, n);
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        s_addr       = '0;
        s_total      = '0;
        s_cmd_valid  = 1'b0;
        s_data       = 32'hDEAD_BEEF;
        s_data_valid = 1'b1;
        m_addr_ready = 1'b1;
        m_data_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (s_cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready got=%b exp=1", s_cmd_ready); end
        total++; if (s_data_ready !== 1'b0) begin bad++; $display("FAIL rst_data_ready got=%b exp=0", s_data_ready); end
        total++; if (m_addr !== 32'h0) begin bad++; $display("FAIL rst_m_addr got=%h exp=0", m_addr); end
        total++; if (m_length !== 8'h0) begin bad++; $display("FAIL rst_m_length got=%h exp=0", m_length); end
        total++; if (m_addr_valid !== 1'b0) begin bad++; $display("FAIL rst_addr_valid got=%b exp=0", m_addr_valid); end
        total++; if (m_data_valid !== 1'b0) begin bad++; $display("FAIL rst_data_valid got=%b exp=0", m_data_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        rst_n        = 1'b1;
        s_data_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [31:0] ea[3];
        logic [7:0]  el[3];
        ea = '{32'h100, 32'h104, 32'h108};
        el = '{8'd3, 8'd3, 8'd1};
        clear_logs();
        send_cmd(32'h100, 16'd9);
        feed(10, 32'hB000_0000, 1'b0);
        total++; if (bq_addr.size() != 3) begin bad++; $display("FAIL basic_nbursts got=%0d exp=3", bq_addr.size()); end
        for (int i = 0; i < 3 && i < bq_addr.size(); i++) begin
            total++; if (bq_addr[i] !== ea[i]) begin bad++; $display("FAIL basic_addr%0d got=%h exp=%h", i, bq_addr[i], ea[i]); end
            total++; if (bq_len[i] !== el[i]) begin bad++; $display("FAIL basic_len%0d got=%0d exp=%0d", i, bq_len[i], el[i]); end
        end
        total++; if (dq.size() != 10) begin bad++; $display("FAIL basic_nbeats got=%0d exp=10", dq.size()); end
        for (int i = 0; i < 10 && i < dq.size(); i++) begin
            total++; if (dq[i] !== 32'hB000_0000 + i) begin bad++; $display("FAIL basic_data%0d got=%h exp=%h", i, dq[i], 32'hB000_0000 + i); end
        end
    endtask

    task automatic test_single();
        clear_logs();
        send_cmd(32'h20, 16'd0);
        feed(1, 32'hC000_0000, 1'b0);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b exp=0", busy); end
        total++; if (s_cmd_ready !== 1'b1) begin bad++; $display("FAIL single_cmd_ready got=%b exp=1", s_cmd_ready); end
        total++; if (bq_addr.size() != 1) begin bad++; $display("FAIL single_nbursts got=%0d exp=1", bq_addr.size()); end
        if (bq_addr.size() > 0) begin
            total++; if (bq_addr[0] !== 32'h20) begin bad++; $display("FAIL single_addr got=%h exp=20", bq_addr[0]); end
            total++; if (bq_len[0] !== 8'd0) begin bad++; $display("FAIL single_len got=%0d exp=0", bq_len[0]); end
        end
        total++; if (dq.size() != 1) begin bad++; $display("FAIL single_nbeats got=%0d exp=1", dq.size()); end
    endtask

    task automatic test_addr_stall();
        clear_logs();
        m_addr_ready = 1'b0;
        m_data_ready = 1'b1;
        send_cmd(32'h40, 16'd5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (m_addr_valid !== 1'b1) begin bad++; $display("FAIL stall_valid%0d got=%b exp=1", i, m_addr_valid); end
            total++; if (m_addr !== 32'h40) begin bad++; $display("FAIL stall_addr%0d got=%h exp=40", i, m_addr); end
            total++; if (m_length !== 8'd3) begin bad++; $display("FAIL stall_len%0d got=%0d exp=3", i, m_length); end
            total++; if (s_data_ready !== 1'b0) begin bad++; $display("FAIL stall_dready%0d got=%b exp=0", i, s_data_ready); end
        end
        @(posedge clk); #1;
        feed(6, 32'hD000_0000, 1'b0);
        total++; if (bq_addr.size() != 2) begin bad++; $display("FAIL stall_nbursts got=%0d exp=2", bq_addr.size()); end
        if (bq_addr.size() > 1) begin
            total++; if (bq_addr[1] !== 32'h44) begin bad++; $display("FAIL stall_addr_b1 got=%h exp=44", bq_addr[1]); end
            total++; if (bq_len[1] !== 8'd1) begin bad++; $display("FAIL stall_len_b1 got=%0d exp=1", bq_len[1]); end
        end
    endtask

    task automatic test_random_stall();
        clear_logs();
        send_cmd(32'h1000, 16'd63);
        feed(64, 32'hE000_0000, 1'b1);
        total++; if (bq_addr.size() != 16) begin bad++; $display("FAIL rand_nbursts got=%0d exp=16", bq_addr.size()); end
        for (int i = 0; i < 16 && i < bq_addr.size(); i++) begin
            total++; if (bq_addr[i] !== 32'h1000 + 4 * i) begin bad++; $display("FAIL rand_addr%0d got=%h exp=%h", i, bq_addr[i], 32'h1000 + 4 * i); end
            total++; if (bq_len[i] !== 8'd3) begin bad++; $display("FAIL rand_len%0d got=%0d exp=3", i, bq_len[i]); end
        end
        total++; if (dq.size() != 64) begin bad++; $display("FAIL rand_nbeats got=%0d exp=64", dq.size()); end
        for (int i = 0; i < 64 && i < dq.size(); i++) begin
            total++; if (dq[i] !== 32'hE000_0000 + i) begin bad++; $display("FAIL rand_data%0d got=%h exp=%h", i, dq[i], 32'hE000_0000 + i); end
        end
    endtask

    // Covers both the alignment split and address wrap past 2^32.
    task automatic test_align();
        logic [31:0] ea[3];
        logic [7:0]  el[3];
        int          nb;
        for (int t = 0; t < 2; t++) begin
`ifdef BURST_WRITE_SPLITTER_ALIGN_EN
            if (t == 0) begin nb = 3; ea = '{32'h102, 32'h104, 32'h108}; el = '{8'd1, 8'd3, 8'd0}; end
            else begin nb = 2; ea = '{32'hFFFF_FFFE, 32'h0, 32'h0}; el = '{8'd1, 8'd3, 8'd0}; end
`else
            if (t == 0) begin nb = 2; ea = '{32'h102, 32'h106, 32'h0}; el = '{8'd3, 8'd2, 8'd0}; end
            else begin nb = 2; ea = '{32'hFFFF_FFFE, 32'h2, 32'h0}; el = '{8'd3, 8'd1, 8'd0}; end
`endif
            clear_logs();
            if (t == 0) begin
                send_cmd(32'h102, 16'd6);
                feed(7, 32'hF000_0000, 1'b0);
            end else begin
                send_cmd(32'hFFFF_FFFE, 16'd5);
                feed(6, 32'hF100_0000, 1'b0);
            end
            total++; if (bq_addr.size() != nb) begin bad++; $display("FAIL align%0d_nbursts got=%0d exp=%0d", t, bq_addr.size(), nb); end
            for (int i = 0; i < nb && i < bq_addr.size(); i++) begin
                total++; if (bq_addr[i] !== ea[i]) begin bad++; $display("FAIL align%0d_addr%0d got=%h exp=%h", t, i, bq_addr[i], ea[i]); end
                total++; if (bq_len[i] !== el[i]) begin bad++; $display("FAIL align%0d_len%0d got=%0d exp=%0d", t, i, bq_len[i], el[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit got_first;
        got_first = 1'b0;
        clear_logs();
        send_cmd(32'h200, 16'd7);
        s_data       = 32'h5000_0000;
        s_data_valid = 1'b1;
        for (int i = 0; i < 20 && !got_first; i++) begin
            @(negedge clk);
            if (s_data_ready) got_first = 1'b1;
            @(posedge clk); #1;
        end
        total++; if (!got_first) begin bad++; $display("FAIL midrst_first_beat got=0 exp=1"); end
        s_data = 32'h5000_0001;
        total++; if (m_data_valid !== 1'b1) begin bad++; $display("FAIL midrst_beat2_valid got=%b exp=1", m_data_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (s_cmd_ready !== 1'b1) begin bad++; $display("FAIL midrst_cmd_ready got=%b exp=1", s_cmd_ready); end
        total++; if (s_data_ready !== 1'b0) begin bad++; $display("FAIL midrst_data_ready got=%b exp=0", s_data_ready); end
        total++; if (m_addr !== 32'h0) begin bad++; $display("FAIL midrst_m_addr got=%h exp=0", m_addr); end
        total++; if (m_length !== 8'h0) begin bad++; $display("FAIL midrst_m_length got=%h exp=0", m_length); end
        total++; if (m_addr_valid !== 1'b0) begin bad++; $display("FAIL midrst_addr_valid got=%b exp=0", m_addr_valid); end
        total++; if (m_data_valid !== 1'b0) begin bad++; $display("FAIL midrst_data_valid got=%b exp=0", m_data_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        s_data_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_logs();
        send_cmd(32'h300, 16'd1);
        feed(2, 32'h6000_0000, 1'b0);
        total++; if (bq_addr.size() != 1) begin bad++; $display("FAIL midrst_nbursts got=%0d exp=1", bq_addr.size()); end
        if (bq_addr.size() > 0) begin
            total++; if (bq_addr[0] !== 32'h300) begin bad++; $display("FAIL midrst_addr got=%h exp=300", bq_addr[0]); end
            total++; if (bq_len[0] !== 8'd1) begin bad++; $display("FAIL midrst_len got=%0d exp=1", bq_len[0]); end
        end
        total++; if (dq.size() != 2) begin bad++; $display("FAIL midrst_nbeats got=%0d exp=2", dq.size()); end
        for (int i = 0; i < 2 && i < dq.size(); i++) begin
            total++; if (dq[i] !== 32'h6000_0000 + i) begin bad++; $display("FAIL midrst_data%0d got=%h exp=%h", i, dq[i], 32'h6000_0000 + i); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_addr_stall();
        test_random_stall();
        test_align();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
